reg_bank_snapshot: RTL and testbench
====================================

REG_BANK_SNAPSHOT -- requirements
Module: reg_bank_snapshot

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W, 32, register width in bits.
  ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
  READ_PORTS, 2, number of independent read ports.
  ZERO_REG, 1, if 1 then register 0 reads 0 and ignores writes.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state changes on the rising edge.
  reset  in  1  asynchronous, active-low reset.
  we  in  1  write enable.
  waddr  in  ADDR_W  write address.
  wdata  in  DATA_W  write data.
  raddr  in  READ_PORTS*ADDR_W  packed read addresses; port k uses slice k.
  rdata  out  READ_PORTS*DATA_W  packed read data; port k uses slice k.
  snap_req  in  1  start a snapshot and dump.
  snap_mode  in  1  0 = full dump; 1 = changed-only dump.
  snap_busy  out  1  snapshot in progress.
  snap_done  out  1  one-cycle pulse when a dump completes.
  dump_valid  out  1  dump entry valid.
  dump_ready  in  1  consumer accepts the entry.
  dump_addr  out  ADDR_W  register index of the entry.
  dump_data  out  DATA_W  snapshot value of the entry.
  dump_last  out  1  final entry of this dump.

Function
REQ-003 Reads SHALL be combinational: rdata[k] = bank[raddr[k]], or 0 when ZERO_REG=1 and raddr[k]=0.
REQ-004 A write SHALL occur on the clock edge when we=1; it is dropped when ZERO_REG=1 and waddr=0.
REQ-005 A read of the address being written SHALL return the old value until the edge.
REQ-006 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-007 In IDLE, snap_req=1 SHALL perform these actions on the same edge:
  - copy the whole bank into the shadow array, using pre-write values at that edge;
  - latch snap_mode;
  - build a DEPTH-bit emit mask;
  - set idx=0 and go to SCAN.
REQ-008 The emit mask SHALL be:
  - all ones in full mode;
  - in changed-only mode, bit i = (shadow[i] != baseline[i]).
REQ-009 In SCAN, when mask[idx]=1:
  - dump_valid=1, dump_addr=idx, dump_data=shadow[idx];
  - these outputs are held stable until dump_valid&&dump_ready;
  - on that handshake idx advances.
REQ-010 In SCAN, when mask[idx]=0, idx SHALL advance without asserting dump_valid (one index per cycle).
REQ-011 dump_last SHALL equal dump_valid AND (no mask bit above idx is set).
REQ-012 SCAN SHALL go to DONE after index DEPTH-1 is handshaken or skipped; no wrap-around is permitted.
REQ-013 DONE SHALL last one cycle, during which:
  - snap_done=1;
  - baseline is replaced by shadow;
  - the FSM returns to IDLE.
REQ-014 A changed-only dump with an empty mask SHALL emit nothing and still pass through DONE, with its snap_done pulse.
REQ-015 snap_busy SHALL be 1 in SCAN and DONE; snap_req while busy SHALL be ignored, not queued.
REQ-016 Writes during SCAN/DONE SHALL update the bank normally and SHALL NOT alter shadow or the current dump.
REQ-017 The baseline SHALL change only in DONE; an interrupted dump leaves the baseline unchanged.

Reset
REQ-018 While reset=0, the block SHALL set asynchronously:
  - all bank, shadow and baseline entries, mask and idx to 0;
  - FSM to IDLE;
  - snap_busy, snap_done, dump_valid and dump_last to 0;
  - dump_addr and dump_data to 0.
REQ-019 Reset asserted mid-dump SHALL abort the dump with no snap_done pulse.
REQ-020 After reset release, the first changed-only dump SHALL compare against an all-zero baseline.

Structure
REQ-021 Package reg_bank_pkg SHALL hold:
  - the FSM state enum (IDLE, SCAN, DONE);
  - default values for DATA_W, ADDR_W and READ_PORTS.
REQ-022 Storage and read muxing SHALL be one sub-module, reg_bank_core (bank plus read ports).
REQ-023 The snapshot/dump FSM, shadow, baseline and mask SHALL stay in the top module.

Verification
REQ-024 Write 0xDEADBEEF to r0 and 0x12345678 to r5 -> rdata reads r0=0, r5=0x12345678 on both ports.
REQ-025 Full dump, ready tied 1, after reset -> 32 entries, addr 0..31, all data 0, last on addr 31, snap_done one cycle later.
REQ-026 Then write r3=7 and r9=9, changed-only dump -> exactly two entries, (3,7) then (9,9) with last on addr 9; a repeat changed-only dump emits nothing and pulses snap_done.
REQ-027 Full dump with dump_ready toggled randomly, plus writes to r4 during SCAN -> dump_addr/dump_data are stable while stalled, r4 shows its pre-snap_req value, and the bank holds the new value afterwards.
REQ-028 Assert reset at the 10th entry of a full dump -> all outputs 0 immediately and no snap_done; the next changed-only dump compares against zero.
REQ-029 snap_req pulsed while snap_busy=1, and snap_req on the same edge as a write to r2 -> the busy request is ignored, and the snapshot holds the old r2.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and default sizes for the snapshotting register bank.
// Holds the dump FSM state enum and the default geometry parameters.
package reg_bank_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 5;
    localparam int READ_PORTS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } snap_state_e;

endpackage

// File: rtl/reg_bank_core.sv
// Register storage with combinational multi-port reads.
// Ports: clk, reset (async low), we/waddr/wdata write port,
// raddr/rdata packed read ports, bank = full storage view for snapshots.
module reg_bank_core
    import reg_bank_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int READ_PORTS = READ_PORTS_DEF,
    parameter int ZERO_REG   = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               we,
    input  logic [ADDR_W-1:0]                  waddr,
    input  logic [DATA_W-1:0]                  wdata,
    input  logic [READ_PORTS*ADDR_W-1:0]       raddr,
    output logic [READ_PORTS*DATA_W-1:0]       rdata,
    output logic [(2**ADDR_W)-1:0][DATA_W-1:0] bank
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic                         wr_ok;

    // r0 stays hard-wired to zero by never accepting a write to it
    assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            if (!((ZERO_REG != 0) && (raddr[k*ADDR_W +: ADDR_W] == '0))) begin
                rdata[k*DATA_W +: DATA_W] = mem[raddr[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign bank = mem;

endmodule

// File: rtl/reg_bank_snapshot.sv
// Register bank with snapshot-and-dump: full or changed-only stream of entries.
// Ports: clk, reset (async low), write/read ports, snap_req/snap_mode control,
// snap_busy/snap_done status, dump_* valid/ready entry stream.
module reg_bank_snapshot
    import reg_bank_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int READ_PORTS = READ_PORTS_DEF,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [READ_PORTS*ADDR_W-1:0] raddr,
    output logic [READ_PORTS*DATA_W-1:0] rdata,
    input  logic                         snap_req,
    input  logic                         snap_mode,
    output logic                         snap_busy,
    output logic                         snap_done,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [ADDR_W-1:0]            dump_addr,
    output logic [DATA_W-1:0]            dump_data,
    output logic                         dump_last
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] bank;
    logic [DEPTH-1:0][DATA_W-1:0] shadow;
    logic [DEPTH-1:0][DATA_W-1:0] baseline;
    logic [DEPTH-1:0]             chg;
    logic [DEPTH-1:0]             chg_d;
    logic [DEPTH-1:0]             emit;
    logic [DEPTH-1:0]             hi;
    logic                         mode_q;
    logic [ADDR_W-1:0]            idx;
    snap_state_e                  state;
    snap_state_e                  state_d;
    logic                         start;
    logic                         hit;
    logic                         adv;

    reg_bank_core #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .READ_PORTS (READ_PORTS),
        .ZERO_REG   (ZERO_REG)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata),
        .bank  (bank)
    );

    // bank still holds pre-write values here, so this equals shadow vs baseline
    always_comb begin
        chg_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            chg_d[i] = (bank[i] != baseline[i]);
        end
    end

    assign emit  = mode_q ? chg : '1;
    assign start = (state == IDLE) && snap_req;
    assign hit   = (state == SCAN) && emit[idx];
    assign adv   = (state == SCAN) && (!emit[idx] || dump_ready);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (snap_req) state_d = SCAN;
            SCAN:    if (adv && (&idx)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shadow   <= '0;
            baseline <= '0;
            chg      <= '0;
            mode_q   <= 1'b0;
            idx      <= '0;
        end else begin
            state <= state_d;
            if (start) begin
                shadow <= bank;
                chg    <= chg_d;
                mode_q <= snap_mode;
                idx    <= '0;
            end else if (adv && !(&idx)) begin
                idx <= idx + 1'b1;
            end
            if (state == DONE) begin
                baseline <= shadow;
            end
        end
    end

    // last entry: no emit bit remains above the current index
    assign hi         = emit >> idx;
    assign dump_valid = hit;
    assign dump_last  = hit && (hi[DEPTH-1:1] == '0);
    assign dump_addr  = hit ? idx : '0;
    assign dump_data  = hit ? shadow[idx] : '0;
    assign snap_busy  = (state != IDLE);
    assign snap_done  = (state == DONE);

endmodule

// File: tb/tb_reg_bank_snapshot.sv
// Scoreboard bench for reg_bank_snapshot: stimulus queues expected dump
// entries, an independent monitor pops and compares each handshake.
module tb_reg_bank_snapshot;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic        snap_req = 1'b0;
    logic        snap_mode = 1'b0;
    logic        snap_busy;
    logic        snap_done;
    logic        dump_valid;
    logic        dump_ready = 1'b1;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_last;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          done_ref = 0;
    int          cyc = 0;
    bit          rnd_ready = 1'b0;
    exp_t        sb[$];
    logic [31:0] mdl[32];
    logic [31:0] base[32];

    reg_bank_snapshot dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .snap_req   (snap_req),
        .snap_mode  (snap_mode),
        .snap_busy  (snap_busy),
        .snap_done  (snap_done),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_last  (dump_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ready driver: tied high or random per cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dump_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor
    bit          prev_stall = 1'b0;
    bit          prev_done = 1'b0;
    bit          saw_last = 1'b0;
    int          last_cyc = 0;
    logic [4:0]  last_a = '0;
    logic [4:0]  prev_a = '0;
    logic [31:0] prev_d = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            saw_last   = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {dump_valid, dump_addr, dump_data},
                      {1'b1, prev_a, prev_d});
            end
            if (dump_valid && dump_ready) begin
                if (sb.size() == 0) begin
                    check("extra_entry", {dump_addr, dump_data}, 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dump_entry", {dump_addr, dump_data, dump_last}, e);
                    if (e.l) begin
                        saw_last = 1'b1;
                        last_cyc = cyc;
                        last_a   = dump_addr;
                    end
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_a     = dump_addr;
            prev_d     = dump_data;
            if (snap_done) begin
                done_cnt++;
                check("done_single", prev_done, 0);
                if (saw_last && last_a == 5'd31) begin
                    check("done_gap", cyc - last_cyc, 1);
                end
                saw_last = 1'b0;
            end
            prev_done = snap_done;
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    task automatic snap(input bit mode, input bit dw,
                        input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        int   lasti;
        lasti = -1;
        for (int i = 0; i < 32; i++)
            if (!mode || mdl[i] != base[i]) lasti = i;
        for (int i = 0; i < 32; i++) begin
            if (!mode || mdl[i] != base[i]) begin
                e.a = i[4:0];
                e.d = mdl[i];
                e.l = (i == lasti);
                sb.push_back(e);
            end
        end
        for (int i = 0; i < 32; i++) base[i] = mdl[i];
        done_ref = done_cnt;
        snap_mode = mode;
        snap_req = 1'b1;
        if (dw) begin
            we = 1'b1;
            waddr = wa;
            wdata = wd;
        end
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        we = 1'b0;
        if (dw && wa != 5'd0) mdl[wa] = wd;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cnt == done_ref && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("snap_done_seen", done_cnt, done_ref + 1);
        check("queue_drained", sb.size(), 0);
        check("busy_clear", snap_busy, 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 32; i++) begin
            mdl[i]  = '0;
            base[i] = '0;
        end
        raddr = {5'd2, 5'd1};
        #3;
        check("rst_outs", {snap_busy, snap_done, dump_valid, dump_last,
                           dump_addr, dump_data}, 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // full dump of an all-zero bank
        snap(1'b0, 1'b0, 5'd0, 32'd0);
        wait_done();

        // changed-only: two entries, then an empty dump
        wr(5'd3, 32'd7);
        wr(5'd9, 32'd9);
        snap(1'b1, 1'b0, 5'd0, 32'd0);
        wait_done();
        snap(1'b1, 1'b0, 5'd0, 32'd0);
        wait_done();

        // r0 ignores writes; read-during-write returns old value
        wr(5'd0, 32'hDEADBEEF);
        raddr = {5'd5, 5'd0};
        we = 1'b1;
        waddr = 5'd5;
        wdata = 32'h12345678;
        #1;
        check("rdw_old", rdata, 64'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        mdl[5] = 32'h12345678;
        check("rd_p0r0_p1r5", rdata, {32'h12345678, 32'h0});
        raddr = {5'd0, 5'd5};
        #1;
        check("rd_p0r5_p1r0", rdata, {32'h0, 32'h12345678});

        // snap_req with a same-edge write to r2; a busy request is dropped
        wr(5'd2, 32'h22);
        snap(1'b0, 1'b1, 5'd2, 32'h2222);
        snap_req = 1'b1;
        check("busy_req_busy", snap_busy, 1);
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        check("busy_req_ignored", {snap_busy, done_cnt}, {1'b0, done_ref + 1});

        // random back-pressure with r4 rewritten during the scan
        wr(5'd4, 32'h44);
        rnd_ready = 1'b1;
        snap(1'b0, 1'b0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        wr(5'd4, 32'h4444);
        wait_done();
        rnd_ready = 1'b0;
        raddr = {5'd4, 5'd4};
        #1;
        check("r4_after", rdata, {32'h4444, 32'h4444});
        @(posedge clk);
        #1;

        // reset at the 10th entry of a full dump
        snap(1'b0, 1'b0, 5'd0, 32'd0);
        k = 0;
        while (!(dump_valid && dump_addr == 5'd9) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("abort_reach", k < 100, 1);
        reset = 1'b0;
        #1;
        check("abort_outs", {snap_busy, snap_done, dump_valid, dump_last,
                             dump_addr, dump_data}, 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, done_ref);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mdl[i]  = '0;
            base[i] = '0;
        end
        @(posedge clk);
        #1;
        raddr = {5'd4, 5'd5};
        #1;
        check("bank_cleared", rdata, 0);
        wr(5'd3, 32'd7);
        snap(1'b1, 1'b0, 5'd0, 32'd0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
